// File: rtl/alu_pkg.sv
// Shared definitions for the vector ALU and its issue controller.
// Covers R_ins function codes, lane-width encodings, FSM states and latency classes.
package alu_pkg;

    localparam logic [5:0] VAND   = 6'b000001;
    localparam logic [5:0] VOR    = 6'b000010;
    localparam logic [5:0] VXOR   = 6'b000011;
    localparam logic [5:0] VNOT   = 6'b000100;
    localparam logic [5:0] VMOV   = 6'b000101;
    localparam logic [5:0] VADD   = 6'b000110;
    localparam logic [5:0] VSUB   = 6'b000111;
    localparam logic [5:0] VMULEU = 6'b001000;
    localparam logic [5:0] VMULOU = 6'b001001;
    localparam logic [5:0] VSLL   = 6'b001010;
    localparam logic [5:0] VSRL   = 6'b001011;
    localparam logic [5:0] VSRA   = 6'b001100;
    localparam logic [5:0] VRTTH  = 6'b001101;
    localparam logic [5:0] VDIV   = 6'b001110;
    localparam logic [5:0] VMOD   = 6'b001111;
    localparam logic [5:0] VSQEU  = 6'b010000;
    localparam logic [5:0] VSQOU  = 6'b010001;
    localparam logic [5:0] VSQRT  = 6'b010010;

    localparam logic [1:0] WW_8  = 2'b00;
    localparam logic [1:0] WW_16 = 2'b01;
    localparam logic [1:0] WW_32 = 2'b10;
    localparam logic [1:0] WW_64 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LAT_SIMPLE = 2'd0,
        LAT_MUL    = 2'd1,
        LAT_DIV    = 2'd2,
        LAT_SQRT   = 2'd3
    } lat_class_t;

    function automatic logic r_ins_legal(input logic [5:0] r_ins);
        return (r_ins >= VAND) && (r_ins <= VSQRT);
    endfunction

    // Illegal instructions (including op_code=0) run on the simple path.
    function automatic lat_class_t lat_class(input logic op_code, input logic [5:0] r_ins);
        if (!op_code) return LAT_SIMPLE;
        case (r_ins)
            VMULEU, VMULOU, VSQEU, VSQOU: return LAT_MUL;
            VDIV, VMOD:                   return LAT_DIV;
            VSQRT:                        return LAT_SQRT;
            default:                      return LAT_SIMPLE;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_alu.sv
// Combinational 64-bit vector ALU; lane width 8<<WW, big-endian lane numbering.
// Multiplies/squares take even or odd lanes of width W and produce 2W-wide products.
module alu_issue_ctrl_alu
    import alu_pkg::*;
(
    input  logic [0:5]  i_r_ins,
    input  logic [1:0]  i_ww,
    input  logic [0:63] i_ra,
    input  logic [0:63] i_rb,
    output logic [0:63] o_alu_out
);

    logic [63:0]      w_a;
    logic [63:0]      w_b;
    logic [5:0]       w_op;
    logic [63:0]      w_out;
    logic [3:0][63:0] w_lane_res;

    assign w_a  = i_ra;
    assign w_b  = i_rb;
    assign w_op = i_r_ins;

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [63:0] x;
        logic [63:0] root;
        logic [63:0] bitv;
        x    = v;
        root = '0;
        bitv = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (x >= root + bitv) begin
                x    = x - (root + bitv);
                root = (root >> 1) + bitv;
            end else begin
                root = root >> 1;
            end
            bitv = bitv >> 2;
        end
        return root[31:0];
    endfunction

    for (genvar gw = 0; gw < 4; gw++) begin : g_width
        localparam int W  = 8 << gw;
        localparam int N  = 64 / W;
        localparam int SW = $clog2(W);

        logic [W-1:0] w_la;
        logic [W-1:0] w_lb;
        logic [63:0]  w_res;
        logic [63:0]  w_mul;

        always_comb begin
            w_res = '0;
            w_la  = '0;
            w_lb  = '0;
            for (int k = 0; k < N; k++) begin
                w_la = w_a[k*W +: W];
                w_lb = w_b[k*W +: W];
                case (w_op)
                    VADD:  w_res[k*W +: W] = w_la + w_lb;
                    VSUB:  w_res[k*W +: W] = w_la - w_lb;
                    VSLL:  w_res[k*W +: W] = w_la << w_lb[SW-1:0];
                    VSRL:  w_res[k*W +: W] = w_la >> w_lb[SW-1:0];
                    VSRA:  w_res[k*W +: W] = $signed(w_la) >>> w_lb[SW-1:0];
                    VRTTH: w_res[k*W +: W] = {w_la[W/2-1:0], w_la[W-1:W/2]};
                    // Zero divisor: quotient 0, remainder passes the dividend.
                    VDIV:  w_res[k*W +: W] = (w_lb == '0) ? '0 : w_la / w_lb;
                    VMOD:  w_res[k*W +: W] = (w_lb == '0) ? w_la : w_la % w_lb;
                    VSQRT: w_res[k*W +: W] = W'(isqrt(64'(w_la)));
                    default: ;
                endcase
            end
        end

        if (gw < 3) begin : g_mul
            localparam int W2 = 2 * W;
            logic [W-1:0] w_ea, w_oa, w_eb, w_ob;

            always_comb begin
                w_mul = '0;
                w_ea  = '0;
                w_oa  = '0;
                w_eb  = '0;
                w_ob  = '0;
                for (int k = 0; k < N / 2; k++) begin
                    w_ea = w_a[k*W2 + W +: W];
                    w_oa = w_a[k*W2 +: W];
                    w_eb = w_b[k*W2 + W +: W];
                    w_ob = w_b[k*W2 +: W];
                    case (w_op)
                        VMULEU: w_mul[k*W2 +: W2] = W2'(w_ea) * W2'(w_eb);
                        VMULOU: w_mul[k*W2 +: W2] = W2'(w_oa) * W2'(w_ob);
                        VSQEU:  w_mul[k*W2 +: W2] = W2'(w_ea) * W2'(w_ea);
                        VSQOU:  w_mul[k*W2 +: W2] = W2'(w_oa) * W2'(w_oa);
                        default: ;
                    endcase
                end
            end
        end else begin : g_no_mul
            assign w_mul = '0;
        end

        // Lane ops and widening ops are mutually exclusive, so OR merges them.
        assign w_lane_res[gw] = w_res | w_mul;
    end

    always_comb begin
        w_out = '0;
        case (w_op)
            VAND:    w_out = w_a & w_b;
            VOR:     w_out = w_a | w_b;
            VXOR:    w_out = w_a ^ w_b;
            VNOT:    w_out = ~w_a;
            VMOV:    w_out = w_a;
            default: w_out = w_lane_res[i_ww];
        endcase
    end

    assign o_alu_out = w_out;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer: holds registered operands on the ALU for an opcode-dependent
// number of cycles, then captures the result and flags behind a valid/ready handshake.
//   state   | meaning
//   ST_IDLE | waiting for an instruction, in_ready=1
//   ST_EXEC | operands held on the ALU, counting down the multicycle latency
//   ST_DONE | result and flags presented until out_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SIMPLE_LAT = 1,
    parameter int MUL_LAT    = 2,
    parameter int DIV_LAT    = 4,
    parameter int SQRT_LAT   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op_code,
    input  logic [0:5]  in_r_ins,
    input  logic [1:0]  in_ww,
    input  logic [0:63] in_ra,
    input  logic [0:63] in_rb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_result,
    output logic        out_illegal,
    output logic        out_div0,
    output logic        busy
);

    if (SIMPLE_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || SQRT_LAT < 1 ||
        SIMPLE_LAT > 256 || MUL_LAT > 256 || DIV_LAT > 256 || SQRT_LAT > 256) begin : g_bad_lat
        $error("alu_issue_ctrl: latency parameters must be in 1..256");
    end

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_op_code;
    logic [5:0]  r_r_ins;
    logic [1:0]  r_ww;
    logic [63:0] r_ra;
    logic [63:0] r_rb;
    logic [63:0] r_result;
    logic        r_illegal;
    logic        r_div0;

    logic        w_accept;
    logic [7:0]  w_cnt_load;
    logic [63:0] w_alu_out;
    logic        w_illegal;
    logic        w_is_div;
    logic        w_zero_lane;
    logic        w_div0;

    alu_issue_ctrl_alu u_alu (
        .i_r_ins   (r_r_ins),
        .i_ww      (r_ww),
        .i_ra      (r_ra),
        .i_rb      (r_rb),
        .o_alu_out (w_alu_out)
    );

    // Gated by reset so every output reads 0 while reset is asserted.
    assign in_ready = reset_n &&
                      ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_cnt_load = 8'(SIMPLE_LAT - 1);
        case (lat_class(in_op_code, in_r_ins))
            LAT_MUL:  w_cnt_load = 8'(MUL_LAT - 1);
            LAT_DIV:  w_cnt_load = 8'(DIV_LAT - 1);
            LAT_SQRT: w_cnt_load = 8'(SQRT_LAT - 1);
            default:  w_cnt_load = 8'(SIMPLE_LAT - 1);
        endcase
    end

    always_comb begin
        w_zero_lane = 1'b0;
        case (r_ww)
            WW_8:    for (int k = 0; k < 8; k++) w_zero_lane |= (r_rb[k*8 +: 8] == 8'h00);
            WW_16:   for (int k = 0; k < 4; k++) w_zero_lane |= (r_rb[k*16 +: 16] == 16'h0000);
            WW_32:   for (int k = 0; k < 2; k++) w_zero_lane |= (r_rb[k*32 +: 32] == 32'h0000_0000);
            default: w_zero_lane = (r_rb == 64'h0);
        endcase
    end

    assign w_illegal = !r_op_code || !r_ins_legal(r_r_ins);
    assign w_is_div  = (r_r_ins == VDIV) || (r_r_ins == VMOD);
    assign w_div0    = !w_illegal && w_is_div && w_zero_lane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op_code <= 1'b0;
            r_r_ins   <= '0;
            r_ww      <= '0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_div0    <= 1'b0;
        end else if (w_accept) begin
            r_op_code <= in_op_code;
            r_r_ins   <= in_r_ins;
            r_ww      <= in_ww;
            r_ra      <= in_ra;
            r_rb      <= in_rb;
            r_cnt     <= w_cnt_load;
            r_state   <= ST_EXEC;
        end else begin
            case (r_state)
                ST_EXEC: begin
                    if (r_cnt == 8'd0) begin
                        r_result  <= w_illegal ? 64'h0 : w_alu_out;
                        r_illegal <= w_illegal;
                        r_div0    <= w_div0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                ST_IDLE: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid   = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign out_result  = r_result;
    assign out_illegal = r_illegal;
    assign out_div0    = r_div0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: expected results are queued at accept time and
// checked by an independent monitor when the controller presents its output.
module tb_alu_issue_ctrl;

    localparam logic [5:0] C_VADD   = 6'b000110;
    localparam logic [5:0] C_VSUB   = 6'b000111;
    localparam logic [5:0] C_VXOR   = 6'b000011;
    localparam logic [5:0] C_VMULEU = 6'b001000;
    localparam logic [5:0] C_VMULOU = 6'b001001;
    localparam logic [5:0] C_VDIV   = 6'b001110;
    localparam logic [5:0] C_VSQRT  = 6'b010010;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_op_code;
    logic [0:5]  in_r_ins;
    logic [1:0]  in_ww;
    logic [0:63] in_ra;
    logic [0:63] in_rb;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_result;
    logic        out_illegal;
    logic        out_div0;
    logic        busy;

    typedef struct {
        logic [63:0] res;
        logic        ill;
        logic        d0;
        longint      t;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   seen     = 0;
    exp_t mon_e;

    alu_issue_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_code  (in_op_code),
        .in_r_ins    (in_r_ins),
        .in_ww       (in_ww),
        .in_ra       (in_ra),
        .in_rb       (in_rb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal),
        .out_div0    (out_div0),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: first out_valid cycle checks latency, the handshake cycle checks data.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got result %h with no pending op", out_result);
            end else begin
                if (!seen) begin
                    seen = 1;
                    check({sb[0].nm, "_latency"}, 64'($time), 64'(sb[0].t));
                end
                if (out_ready) begin
                    mon_e = sb.pop_front();
                    seen  = 0;
                    check({mon_e.nm, "_result"}, out_result, mon_e.res);
                    check({mon_e.nm, "_illegal"}, 64'(out_illegal), 64'(mon_e.ill));
                    check({mon_e.nm, "_div0"}, 64'(out_div0), 64'(mon_e.d0));
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input string nm, input logic opc, input logic [5:0] ri,
                         input logic [1:0] ww, input logic [63:0] ra, input logic [63:0] rb,
                         input logic [63:0] er, input logic ei, input logic ed,
                         input int lat, input bit push, output int waited);
        exp_t e;
        in_op_code = opc;
        in_r_ins   = ri;
        in_ww      = ww;
        in_ra      = ra;
        in_rb      = rb;
        in_valid   = 1'b1;
        waited     = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles, required 1", nm, waited);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) begin
            e.res = er;
            e.ill = ei;
            e.d0  = ed;
            e.t   = longint'($time) + lat * 10 + 5;
            e.nm  = nm;
            sb.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        bit saw;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_op_code = 1'b0;
        in_r_ins   = '0;
        in_ww      = '0;
        in_ra      = '0;
        in_rb      = '0;
        out_ready  = 1'b1;
        #2;
        check("reset_outputs", {57'h0, in_ready, out_valid, busy, out_illegal, out_div0, 2'b00}, 64'h0);
        check("reset_result", out_result, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("idle_ready", {62'h0, in_ready, busy}, 64'h2);

        issue("vadd", 1'b1, C_VADD, 2'b00, 64'd5, 64'd10, 64'd15, 1'b0, 1'b0, 1, 1, w);
        drain();

        issue("vdiv", 1'b1, C_VDIV, 2'b00, 64'hFF123456_78786345, 64'hFFFF3401_FFDE3211,
              64'h01000156_00000104, 1'b0, 1'b0, 4, 1, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("vdiv_busy_exec", {62'h0, busy, out_valid}, 64'h2);
        end
        drain();

        issue("vdiv_zero8", 1'b1, C_VDIV, 2'b00, 64'hFF123456_78786345, 64'hFF00FF00_FF00FF00,
              64'h01000000_00000000, 1'b0, 1'b1, 4, 1, w);
        drain();
        issue("vdiv_ww32", 1'b1, C_VDIV, 2'b10, 64'hFF123456_78786345, 64'hFF00FF00_FF00FF00,
              64'h00000001_00000000, 1'b0, 1'b0, 4, 1, w);
        drain();

        issue("illegal_3f", 1'b1, 6'b111111, 2'b00, 64'h12345678_9ABCDEF0, 64'h1,
              64'h0, 1'b1, 1'b0, 1, 1, w);
        drain();
        issue("opcode0_vadd", 1'b0, C_VADD, 2'b00, 64'd5, 64'd10, 64'h0, 1'b1, 1'b0, 1, 1, w);
        drain();
        issue("opcode0_vdiv", 1'b0, C_VDIV, 2'b00, 64'hFF123456_78786345, 64'hFF00FF00_FF00FF00,
              64'h0, 1'b1, 1'b0, 1, 1, w);
        drain();

        issue("vmulou", 1'b1, C_VMULOU, 2'b00, 64'hFF000000_FFFFFFFF, 64'hFF020001_CC0F0001,
              64'h00000000_0EF100FF, 1'b0, 1'b0, 2, 1, w);
        drain();
        issue("vsqrt", 1'b1, C_VSQRT, 2'b10, 64'h00000051_00010000, 64'h0,
              64'h00000009_00000100, 1'b0, 1'b0, 4, 1, w);
        drain();

        // Backpressure with a competing instruction held on the input.
        out_ready = 1'b0;
        issue("vmuleu", 1'b1, C_VMULEU, 2'b10, 64'hFF000000_FFFFFFFF, 64'hFF020001_CC0F0001,
              64'hFE02FE00_FF000000, 1'b0, 1'b0, 2, 1, w);
        in_op_code = 1'b1;
        in_r_ins   = C_VSUB;
        in_ww      = 2'b00;
        in_ra      = 64'h0;
        in_rb      = 64'h1;
        in_valid   = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_result", out_result, 64'hFE02FE00_FF000000);
            check("bp_hold_ctrl", {59'h0, out_valid, in_ready, busy, out_illegal, out_div0}, 64'h14);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue("vsub_b2b", 1'b1, C_VSUB, 2'b00, 64'h0, 64'h1, 64'h00000000_000000FF,
              1'b0, 1'b0, 1, 1, w);
        check("b2b_same_cycle_accept", 64'(w), 64'h0);
        drain();

        // Reset during VSQRT execution discards the operation.
        issue("vsqrt_abort", 1'b1, C_VSQRT, 2'b00, 64'h51, 64'h0, 64'h0, 1'b0, 1'b0, 4, 0, w);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check("midop_reset_outputs",
                 {57'h0, in_ready, out_valid, busy, out_illegal, out_div0, 2'b00}, 64'h0);
        check("midop_reset_result", out_result, 64'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            saw |= out_valid;
        end
        check("no_output_after_abort", 64'(saw), 64'h0);
        @(posedge clk);
        #1;
        issue("vxor_after_reset", 1'b1, C_VXOR, 2'b11, 64'hFFFF0000_12345678, 64'h0F0F0F0F_0F0F0F0F,
              64'hF0F00F0F_1D3B5977, 1'b0, 1'b0, 1, 1, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
